// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing a single-port, one-cycle-latency program memory
// between the core's instruction-fetch and data req/gnt/rvalid interfaces.
// Out-of-window addresses, and writes when ReadOnly is set, are answered
// locally with an error response and never reach the memory.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   instr_* / data_*  (inputs)     req, we, be, addr, wdata from each requester
//   instr_* / data_*  (outputs)    gnt (combinational), rvalid, rdata, err
//   mem_*_o                        request to the memory (combinational)
//   mem_rvalid_i, mem_rdata_i      memory response, one cycle after mem_req_o
module rom_arbiter #(
  parameter logic [31:0] BaseAddr = 32'h0000_0000,
  parameter int unsigned Depth    = 256,
  parameter bit          ReadOnly = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  input  logic        instr_we_i,
  input  logic [3:0]  instr_be_i,
  input  logic [31:0] instr_addr_i,
  input  logic [31:0] instr_wdata_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [31:0] AddrMask = 32'(Depth * 4 - 1);

  typedef enum logic {
    PortInstr = 1'b0,
    PortData  = 1'b1
  } port_e;

  port_e      last_winner_q, last_winner_d;
  port_e      owner_id_q, owner_id_d;
  logic       owner_valid_q, owner_valid_d;
  logic [1:0] err_pending_q, err_pending_d;

  logic instr_bad, data_bad;
  logic instr_good, data_good;
  logic instr_win, data_win;
  logic instr_mem_rsp, data_mem_rsp;

  // Range/permission check, arbitration, memory mux and next-state.
  always_comb begin
    instr_bad  = instr_req_i &&
                 (((instr_addr_i & ~AddrMask) != BaseAddr) || (ReadOnly && instr_we_i));
    data_bad   = data_req_i &&
                 (((data_addr_i & ~AddrMask) != BaseAddr) || (ReadOnly && data_we_i));
    instr_good = instr_req_i && !instr_bad;
    data_good  = data_req_i && !data_bad;

    instr_win = 1'b0;
    data_win  = 1'b0;
    if (instr_good && data_good) begin
      // On conflict the port that did not win the last memory grant goes.
      if (last_winner_q == PortData) instr_win = 1'b1;
      else                           data_win  = 1'b1;
    end else begin
      instr_win = instr_good;
      data_win  = data_good;
    end

    // Bad requests are accepted immediately; they never occupy the memory.
    instr_gnt_o = instr_bad || instr_win;
    data_gnt_o  = data_bad || data_win;

    mem_req_o   = instr_win || data_win;
    mem_we_o    = instr_we_i;
    mem_be_o    = instr_be_i;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = instr_wdata_i;
    if (data_win) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end

    last_winner_d = last_winner_q;
    if (instr_win)     last_winner_d = PortInstr;
    else if (data_win) last_winner_d = PortData;

    owner_valid_d = instr_win || data_win;
    owner_id_d    = data_win ? PortData : PortInstr;
    err_pending_d = {data_bad, instr_bad};
  end

  // Arbitration and response-tracking state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_winner_q <= PortData;
      owner_valid_q <= 1'b0;
      owner_id_q    <= PortInstr;
      err_pending_q <= 2'b00;
    end else begin
      last_winner_q <= last_winner_d;
      owner_valid_q <= owner_valid_d;
      owner_id_q    <= owner_id_d;
      err_pending_q <= err_pending_d;
    end
  end

  // Route the memory response to its owner, or return a local error.
  always_comb begin
    instr_mem_rsp  = mem_rvalid_i && owner_valid_q && (owner_id_q == PortInstr);
    data_mem_rsp   = mem_rvalid_i && owner_valid_q && (owner_id_q == PortData);
    instr_rvalid_o = instr_mem_rsp || err_pending_q[0];
    data_rvalid_o  = data_mem_rsp || err_pending_q[1];
    instr_rdata_o  = instr_mem_rsp ? mem_rdata_i : 32'h0;
    data_rdata_o   = data_mem_rsp ? mem_rdata_i : 32'h0;
    instr_err_o    = err_pending_q[0];
    data_err_o     = err_pending_q[1];
  end

endmodule
